timer_capture_compare: RTL and testbench
========================================

Name: timer_capture_compare

Overview:
- Sits directly downstream of the peripheral timer. It consumes the free-running 32-bit `timer` count and produces timestamped capture events and compare-match events.
- Capture: an external pin edge is synchronised and the current `timer` value is pushed into a small FIFO.
- Compare: a single compare channel flags equality with the timer count.
- A masked, acknowledgeable interrupt aggregates the event sources for the SoC interrupt controller.

Parameters:
- FIFO_DEPTH, 4, capture FIFO entries; power of two, 2..16.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of `cap_count`.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- timer  in  32  live count from the timer block.
- compare_val  in  32  compare target.
- compare_en  in  1  enables compare-match detection.
- capture_in  in  1  external asynchronous capture pin.
- capture_edge  in  2  edge select: 00 off, 01 rising, 10 falling, 11 both.
- cap_rd_en  in  1  pop one FIFO entry.
- cap_rd_data  out  32  popped timestamp.
- cap_rd_valid  out  1  `cap_rd_data` valid this cycle.
- cap_count  out  CNT_W  current FIFO occupancy.
- irq_mask  in  3  per-source interrupt enable.
- irq_ack  in  3  write-1-to-clear for the status bits.
- irq_status  out  3  pending bits:
  - [0] compare match
  - [1] capture FIFO non-empty
  - [2] capture overflow
- irq  out  1  registered, `|(irq_status & irq_mask)`.

Behaviour:
- Reset (rst=0, async):
  - All of `cap_rd_data`, `cap_rd_valid`, `cap_count`, `irq_status`, `irq` go to 0.
  - FIFO pointers clear.
  - Synchroniser flops go to 0.
  - Warm-up counter loads 2.
- Synchroniser: 2-flop on `capture_in`, plus a third "previous" flop for edge detect.
  - Edge detection is suppressed while the warm-up counter is non-zero.
  - The counter decrements once per cycle after reset release, so a pin held high through reset produces no spurious rising edge.
- Edge qualify:
  - rise = sync & ~prev; fall = ~sync & prev.
  - event = (rise & capture_edge[0]) | (fall & capture_edge[1]).
  - Pin change to push latency is 3 clk. The stored value is `timer` as sampled in the push cycle.
- FIFO push on event:
  - If not full: write `timer`, increment `cap_count`.
  - If full and no pop in the same cycle: drop the sample and set `irq_status[2]` (sticky).
  - If full and a pop occurs in the same cycle: pop, then push. Net count unchanged, no overflow.
- FIFO pop:
  - `cap_rd_en` with count>0: `cap_rd_data` = head entry and `cap_rd_valid`=1 on the next cycle; decrement count.
  - `cap_rd_en` with count==0: ignored; `cap_rd_valid`=0 next cycle and `cap_rd_data` holds its last value.
  - `cap_rd_valid` is a 1-cycle pulse per successful pop.
  - Pointers wrap modulo FIFO_DEPTH.
- irq_status[1]: level. Equals (count != 0) after the current push/pop, registered. `irq_ack[1]` has no effect on it.
- Compare:
  - `timer_q` = `timer` registered.
  - match = compare_en & (timer == compare_val) & (timer_q != compare_val).
  - The match is edge-sensitive, so a stalled timer sitting on `compare_val` sets the bit once only.
  - A wrap through 0xFFFFFFFF→0 requires no special handling.
  - match sets `irq_status[0]` on the next clk.
- Sticky bits [0] and [2]: cleared by the matching `irq_ack` bit. If a set and an ack occur in the same cycle, the set wins (bit stays 1).
- irq: registered from `irq_status & irq_mask`, so it lags a status change by 1 cycle. Changing the mask affects `irq` on the next cycle.
- capture_edge=00: no pushes. Entries already in the FIFO remain readable.
- Reset mid-operation: FIFO contents are discarded, all status clears, and the warm-up counter restarts.

Test Plan:
1. Reset release with `capture_in`=1, `capture_edge`=01 → no push for the first cycles; `cap_count`=0 and `irq_status`=000.
2. `capture_edge`=01, `timer` incrementing from 100, rising edge on `capture_in` at timer=100 → push on the 3rd clk.
   - Pop → `cap_rd_valid` pulses one cycle later with `cap_rd_data`=103.
   - `irq_status[1]` =1 while the entry is held, 0 after the pop.
3. FIFO_DEPTH=4, `capture_edge`=11, 5 edges with no reads → `cap_count`=4, `irq_status[2]`=1, 5th sample dropped.
   - `irq_ack`=100 → bit [2] clears.
   - 4 pops return the first 4 timestamps in order; a 5th `cap_rd_en` gives `cap_rd_valid`=0.
4. FIFO full and edge coincident with `cap_rd_en` → `cap_count` stays 4, `irq_status[2]` stays 0, oldest entry popped.
5. compare_val=0x00000005, compare_en=1, `timer` ramps 3..8 → `irq_status[0]`=1 one cycle after timer=5.
   - With `irq_mask`=001, `irq`=1 one cycle later.
   - Timer held at 5 plus `irq_ack`=001 → bit clears and does not re-set.
   - `irq_ack[0]` in the same cycle as a new match → bit stays 1.
6. compare_val=0, timer ramps 0xFFFFFFFE→0x00000001 → exactly one match (at wrap to 0).
   - Asserting rst=0 mid-sequence → all outputs 0 immediately (async).

Source files
------------

// File: rtl/timer_capture_compare.sv
// Capture/compare unit fed by the free-running 32-bit timer: timestamps synchronised
// pin edges into a small FIFO, flags compare matches, and raises a masked interrupt.
module timer_capture_compare #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      timer,
    input  logic [31:0]      compare_val,
    input  logic             compare_en,
    input  logic             capture_in,
    input  logic [1:0]       capture_edge,
    input  logic             cap_rd_en,
    output logic [31:0]      cap_rd_data,
    output logic             cap_rd_valid,
    output logic [CNT_W-1:0] cap_count,
    input  logic [2:0]       irq_mask,
    input  logic [2:0]       irq_ack,
    output logic [2:0]       irq_status,
    output logic             irq
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned TS_W   = 32;
    localparam int unsigned IRQ_W  = 3;
    localparam int unsigned WARM_W = 2;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(2);

    // Pin synchroniser and edge detector state
    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic [WARM_W-1:0] r_warm;
    logic              r_armed;
    logic              r_evt;

    // Capture FIFO
    logic [TS_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [TS_W-1:0]   r_rd_data;
    logic              r_rd_valid;

    // Compare and interrupt state
    logic [TS_W-1:0]   r_timer_q;
    logic [IRQ_W-1:0]  r_status;
    logic              r_irq;

    logic              w_rise;
    logic              w_fall;
    logic              w_event;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf;
    logic              w_match;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [IRQ_W-1:0]  w_status_nxt;
    logic              w_unused_ack;

    // The FIFO-level bit follows occupancy, so its acknowledge bit is a no-op.
    assign w_unused_ack = irq_ack[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_warm  <= WARM_INIT;
            r_armed <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_sync1 <= capture_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_warm != '0) begin
                r_warm <= r_warm - WARM_W'(1);
            end
            // Arms one cycle after warm-up ends so reset-time flop values never form an edge
            r_armed <= (r_warm == '0);
            r_evt   <= w_event;
        end
    end

    // Edge qualification, FIFO control and next status
    always_comb begin
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_event      = 1'b0;
        w_full       = 1'b0;
        w_empty      = 1'b0;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_ovf        = 1'b0;
        w_match      = 1'b0;
        w_count_nxt  = r_count;
        w_status_nxt = r_status;

        w_rise  = r_sync2 & ~r_prev;
        w_fall  = ~r_sync2 & r_prev;
        w_event = r_armed & ((w_rise & capture_edge[0]) | (w_fall & capture_edge[1]));

        w_full  = (r_count == FULL_CNT);
        w_empty = (r_count == '0);
        w_pop   = cap_rd_en & ~w_empty;
        w_push  = r_evt & (~w_full | w_pop);
        w_ovf   = r_evt & w_full & ~w_pop;

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase

        // Edge-sensitive match: a timer parked on the target fires only once
        w_match = compare_en & (timer == compare_val) & (r_timer_q != compare_val);

        w_status_nxt[0] = w_match | (r_status[0] & ~irq_ack[0]);
        w_status_nxt[1] = (w_count_nxt != '0);
        w_status_nxt[2] = w_ovf | (r_status[2] & ~irq_ack[2]);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= timer;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_timer_q  <= '0;
            r_status   <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            // Head is read before a same-cycle write into the slot it frees
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_pop;
            r_count    <= w_count_nxt;
            r_timer_q  <= timer;
            r_status   <= w_status_nxt;
            r_irq      <= |(r_status & irq_mask);
        end
    end

    assign cap_rd_data  = r_rd_data;
    assign cap_rd_valid = r_rd_valid;
    assign cap_count    = r_count;
    assign irq_status   = r_status;
    assign irq          = r_irq;

endmodule

// File: tb/tb_timer_capture_compare.sv
// Bench for timer_capture_compare: queue-based model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_timer_capture_compare;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             rst;
    logic [31:0]      timer;
    logic [31:0]      compare_val;
    logic             compare_en;
    logic             capture_in;
    logic [1:0]       capture_edge;
    logic             cap_rd_en;
    logic [31:0]      cap_rd_data;
    logic             cap_rd_valid;
    logic [CNT_W-1:0] cap_count;
    logic [2:0]       irq_mask;
    logic [2:0]       irq_ack;
    logic [2:0]       irq_status;
    logic             irq;

    timer_capture_compare #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .timer        (timer),
        .compare_val  (compare_val),
        .compare_en   (compare_en),
        .capture_in   (capture_in),
        .capture_edge (capture_edge),
        .cap_rd_en    (cap_rd_en),
        .cap_rd_data  (cap_rd_data),
        .cap_rd_valid (cap_rd_valid),
        .cap_count    (cap_count),
        .irq_mask     (irq_mask),
        .irq_ack      (irq_ack),
        .irq_status   (irq_status),
        .irq          (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total;
    int          bad;
    bit          ramp;
    logic [31:0] stamp [5];
    logic [31:0] s_last;

    // Model state: pin samples and edge selects per clock since reset, FIFO as a queue
    bit          m_pin [$];
    logic [1:0]  m_sel [$];
    logic [31:0] m_q [$];
    logic [31:0] m_rd_data;
    logic        m_rd_valid;
    logic [2:0]  m_stat;
    logic        m_irq;
    logic [31:0] m_tprev;
    int          m_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pin.delete();
        m_sel.delete();
        m_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_stat     = '0;
        m_irq      = 1'b0;
        m_tprev    = '0;
        m_k        = 0;
    endtask

    // A pin change first sampled at clock k-3 is pushed at clock k; samples from before reset never count
    task automatic model_step();
        bit   ev;
        bit   pop;
        bit   ovf;
        bit   match;
        logic irq_n;
        m_pin.push_back(capture_in);
        m_sel.push_back(capture_edge);
        ev = 1'b0;
        if (m_k >= 4 && m_pin[m_k-3] != m_pin[m_k-4])
            ev = m_pin[m_k-3] ? m_sel[m_k-1][0] : m_sel[m_k-1][1];
        irq_n = |(m_stat & irq_mask);
        pop = cap_rd_en && (m_q.size() > 0);
        m_rd_valid = pop;
        if (pop) m_rd_data = m_q.pop_front();
        ovf = 1'b0;
        if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(timer);
            else ovf = 1'b1;
        end
        match = compare_en && (timer == compare_val) && (m_tprev != compare_val);
        m_stat[0] = match | (m_stat[0] & ~irq_ack[0]);
        m_stat[1] = (m_q.size() != 0);
        m_stat[2] = ovf | (m_stat[2] & ~irq_ack[2]);
        m_irq   = irq_n;
        m_tprev = timer;
        m_k++;
    endtask

    task automatic nxt(input int n);
        repeat (n) begin
            @(negedge clk);
            if (ramp) timer = timer + 32'd1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ramp  = 1'b1;
        timer = 32'd0;
        compare_val  = 32'hDEAD_0000;
        compare_en   = 1'b0;
        capture_in   = 1'b1;
        capture_edge = 2'b01;
        cap_rd_en    = 1'b0;
        irq_mask     = 3'b000;
        irq_ack      = 3'b000;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;

        fork
            forever begin
                @(posedge clk or negedge rst);
                if (!rst) model_reset();
                else model_step();
            end
            forever begin
                @(negedge clk);
                chk("cyc_count", 32'(cap_count), 32'(m_q.size()));
                chk("cyc_valid", 32'(cap_rd_valid), 32'(m_rd_valid));
                chk("cyc_data", cap_rd_data, m_rd_data);
                chk("cyc_status", 32'(irq_status), 32'(m_stat));
                chk("cyc_irq", 32'(irq), 32'(m_irq));
            end
        join_none

        // Reset values, then release with the pin held high
        nxt(2);
        chk("rst_data", cap_rd_data, 32'd0);
        chk("rst_valid", 32'(cap_rd_valid), 32'd0);
        chk("rst_count", 32'(cap_count), 32'd0);
        chk("rst_status", 32'(irq_status), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b1;
        nxt(8);
        chk("warm_count", 32'(cap_count), 32'd0);
        chk("warm_status", 32'(irq_status), 32'd0);

        // Single rising edge at timer=100, then pop
        capture_in = 1'b0;
        nxt(6);
        timer = 32'd100;
        capture_in = 1'b1;
        nxt(3);
        chk("lat_count_before", 32'(cap_count), 32'd0);
        nxt(1);
        chk("lat_count_after", 32'(cap_count), 32'd1);
        chk("lat_status", 32'(irq_status), 32'b010);
        cap_rd_en = 1'b1;
        nxt(1);
        cap_rd_en = 1'b0;
        chk("pop_valid", 32'(cap_rd_valid), 32'd1);
        chk("pop_data", cap_rd_data, 32'd103);
        chk("pop_status", 32'(irq_status), 32'b000);
        nxt(1);
        chk("pop_pulse", 32'(cap_rd_valid), 32'd0);

        // Both edges, five captures into a four-deep FIFO
        capture_edge = 2'b11;
        for (int i = 0; i < 5; i++) begin
            capture_in = ~capture_in;
            stamp[i] = timer + 32'd3;
            nxt(2);
        end
        nxt(4);
        chk("ovf_count", 32'(cap_count), 32'd4);
        chk("ovf_status", 32'(irq_status), 32'b110);
        irq_ack = 3'b100;
        nxt(1);
        irq_ack = 3'b000;
        chk("ovf_ack", 32'(irq_status), 32'b010);
        cap_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nxt(1);
            chk("drain_valid", 32'(cap_rd_valid), 32'd1);
            chk("drain_data", cap_rd_data, stamp[i]);
        end
        nxt(1);
        cap_rd_en = 1'b0;
        chk("empty_valid", 32'(cap_rd_valid), 32'd0);
        chk("empty_hold", cap_rd_data, stamp[3]);

        // Full FIFO with a capture coinciding with a pop
        for (int i = 0; i < 4; i++) begin
            capture_in = ~capture_in;
            stamp[i] = timer + 32'd3;
            nxt(2);
        end
        nxt(4);
        chk("full_count", 32'(cap_count), 32'd4);
        capture_in = ~capture_in;
        s_last = timer + 32'd3;
        nxt(3);
        cap_rd_en = 1'b1;
        nxt(1);
        chk("coin_count", 32'(cap_count), 32'd4);
        chk("coin_status", 32'(irq_status), 32'b010);
        chk("coin_data", cap_rd_data, stamp[0]);
        for (int i = 1; i < 4; i++) begin
            nxt(1);
            chk("coin_drain", cap_rd_data, stamp[i]);
        end
        nxt(1);
        cap_rd_en = 1'b0;
        chk("coin_last", cap_rd_data, s_last);

        // Edge select off: toggles capture nothing
        capture_edge = 2'b00;
        for (int i = 0; i < 3; i++) begin
            capture_in = ~capture_in;
            nxt(2);
        end
        nxt(4);
        chk("off_count", 32'(cap_count), 32'd0);

        // Compare channel
        ramp = 1'b0;
        compare_val = 32'd5;
        compare_en  = 1'b1;
        irq_mask    = 3'b001;
        timer = 32'd3;
        nxt(1); timer = 32'd4;
        nxt(1); timer = 32'd5;
        nxt(1); timer = 32'd6;
        chk("cmp_set", 32'(irq_status), 32'b001);
        chk("cmp_irq_lag", 32'(irq), 32'd0);
        nxt(1); timer = 32'd7;
        chk("cmp_irq", 32'(irq), 32'd1);
        nxt(1); timer = 32'd8; irq_ack = 3'b001;
        nxt(1); timer = 32'd5; irq_ack = 3'b000;
        nxt(1);
        chk("hold_set", 32'(irq_status), 32'b001);
        irq_ack = 3'b001;
        nxt(1);
        irq_ack = 3'b000;
        chk("hold_ack", 32'(irq_status), 32'b000);
        nxt(1);
        chk("hold_no_reset", 32'(irq_status), 32'b000);
        timer = 32'd6;
        nxt(1); timer = 32'd5; irq_ack = 3'b001;
        nxt(1);
        irq_ack = 3'b000;
        chk("set_wins", 32'(irq_status), 32'b001);
        irq_mask = 3'b000;
        nxt(1);
        chk("mask_off", 32'(irq), 32'd0);
        irq_mask = 3'b001;
        nxt(1);
        chk("mask_on", 32'(irq), 32'd1);

        // Wrap through all-ones to zero
        compare_val = 32'd0;
        timer = 32'hFFFF_FFFE;
        irq_ack = 3'b001;
        nxt(1); timer = 32'hFFFF_FFFF; irq_ack = 3'b000;
        chk("wrap_clear", 32'(irq_status), 32'b000);
        nxt(1); timer = 32'd0;
        nxt(1); timer = 32'd1;
        chk("wrap_match", 32'(irq_status), 32'b001);
        irq_ack = 3'b001;
        nxt(1); timer = 32'd2; irq_ack = 3'b000;
        chk("wrap_once", 32'(irq_status), 32'b000);
        nxt(2);
        chk("wrap_quiet", 32'(irq_status), 32'b000);
        chk("pre_rst_data", cap_rd_data, s_last);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("async_data", cap_rd_data, 32'd0);
        chk("async_valid", 32'(cap_rd_valid), 32'd0);
        chk("async_count", 32'(cap_count), 32'd0);
        chk("async_status", 32'(irq_status), 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        nxt(2);
        rst = 1'b1;
        nxt(4);
        chk("post_count", 32'(cap_count), 32'd0);
        chk("post_status", 32'(irq_status), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
